ro_pwm_gen: RTL and testbench

//  MSP430 peripheral generating PWM_out, the gating strobe for the RO short/long sensor peripheral.

---
 rtl/ro_pwm_gen_pkg.sv | 26 ++
 rtl/ro_pwm_prescaler.sv | 35 +++
 rtl/ro_pwm_gen.sv | 165 ++++++++++++++++
 tb/tb_ro_pwm_gen.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ro_pwm_gen_pkg.sv
// Shared register map, bit positions and FSM encoding for the RO PWM strobe generator.
package ro_pwm_gen_pkg;

  // byte offsets from BASE_ADDR
  localparam logic [3:0] OFS_CTRL   = 4'h0;
  localparam logic [3:0] OFS_PERIOD = 4'h2;
  localparam logic [3:0] OFS_DUTY   = 4'h4;
  localparam logic [3:0] OFS_CNT    = 4'h6;
  localparam logic [3:0] OFS_BURST  = 4'h8;
  localparam logic [3:0] OFS_STAT   = 4'hA;

  localparam int unsigned CTRL_EN    = 0;
  localparam int unsigned CTRL_POL   = 1;
  localparam int unsigned CTRL_PS_LO = 2;
  localparam int unsigned CTRL_PS_HI = 3;
  localparam int unsigned CTRL_IE    = 4;

  localparam int unsigned STAT_PD = 0;
  localparam int unsigned STAT_BD = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } pwm_state_e;

endpackage

// File: rtl/ro_pwm_prescaler.sv
// Clock-enable prescaler for the PWM counter: tick every 1/2/4/8 mclk cycles while enabled.
module ro_pwm_prescaler (
  input  logic       mclk,
  input  logic       puc_rst,
  input  logic       en,
  input  logic [1:0] presc,
  output logic       tick
);

  logic [2:0] count;
  logic [2:0] limit;

  always_comb begin
    limit = 3'd0;
    case (presc)
      2'd0: limit = 3'd0;
      2'd1: limit = 3'd1;
      2'd2: limit = 3'd3;
      2'd3: limit = 3'd7;
      default: limit = 3'd0;
    endcase
  end

  assign tick = en & (count == limit);

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst)
      count <= '0;
    else if (!en || tick)
      count <= '0;
    else
      count <= count + 3'd1;
  end

endmodule

// File: rtl/ro_pwm_gen.sv
// PWM gating strobe for the RO sensor peripheral, on the MSP430 per_* bus.
// Optional burst mode (fixed number of periods) enabled by macro RO_PWM_BURST_EN.
module ro_pwm_gen
  import ro_pwm_gen_pkg::*;
#(
  parameter logic [14:0] BASE_ADDR = 15'h01A0,
  parameter int unsigned DEC_WD    = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  output logic [15:0] per_dout,
  output logic        pwm_out,
  output logic        irq
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic              reg_sel, reg_wr, reg_rd;
  logic [DEC_WD-1:0] reg_ofs;
  logic              wr_ctrl, wr_period, wr_duty, wr_stat;

  logic              ctrl_en, ctrl_pol, ctrl_ie;
  logic [1:0]        ctrl_presc;
  logic [CNT_W-1:0]  period_sh, duty_sh, per_act, duty_act, cnt;
  logic              stat_pd, stat_bd;
  pwm_state_e        state, next_state;

  logic              active, tick, wrap, start, burst_end;
  logic [15:0]       burst_rd;

  assign reg_sel   = per_en & (per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
  assign reg_ofs   = {per_addr[DEC_WD-2:0], 1'b0};
  assign reg_wr    = reg_sel & (|per_we);
  assign reg_rd    = reg_sel & ~(|per_we);
  assign wr_ctrl   = reg_wr & (reg_ofs == OFS_CTRL);
  assign wr_period = reg_wr & (reg_ofs == OFS_PERIOD);
  assign wr_duty   = reg_wr & (reg_ofs == OFS_DUTY);
  assign wr_stat   = reg_wr & (reg_ofs == OFS_STAT);

  // Gating on the live EN bit as well as the state lets a software stop
  // silence the strobe and clear the counter one edge after the write.
  assign active = (state == ST_RUN) & ctrl_en;
  assign start  = (state == ST_IDLE) & ctrl_en;
  assign wrap   = active & tick & (cnt == per_act);

  ro_pwm_prescaler u_presc (
    .mclk    (mclk),
    .puc_rst (puc_rst),
    .en      (active),
    .presc   (ctrl_presc),
    .tick    (tick)
  );

`ifdef RO_PWM_BURST_EN
  logic        wr_burst;
  logic [15:0] burst_prog, burst_rem;

  assign wr_burst  = reg_wr & (reg_ofs == OFS_BURST);
  assign burst_end = wrap & (burst_rem == 16'd1);
  assign burst_rd  = (state == ST_RUN) ? burst_rem : burst_prog;

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      burst_prog <= '0;
      burst_rem  <= '0;
    end else begin
      if (wr_burst)
        burst_prog <= per_din;
      if (start)
        burst_rem <= burst_prog;
      else if (wrap && (burst_rem != '0))
        burst_rem <= burst_rem - 16'd1;
    end
  end
`else
  assign burst_end = 1'b0;
  assign burst_rd  = '0;
`endif

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst)
      state <= ST_IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (ctrl_en) next_state = ST_RUN;
      ST_RUN:  if (!ctrl_en || burst_end) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      ctrl_en    <= 1'b0;
      ctrl_pol   <= 1'b0;
      ctrl_presc <= '0;
      ctrl_ie    <= 1'b0;
      period_sh  <= '0;
      duty_sh    <= '0;
      stat_pd    <= 1'b0;
      stat_bd    <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_en    <= per_din[CTRL_EN];
        ctrl_pol   <= per_din[CTRL_POL];
        ctrl_presc <= per_din[CTRL_PS_HI:CTRL_PS_LO];
        ctrl_ie    <= per_din[CTRL_IE];
      end
      if (burst_end)
        ctrl_en <= 1'b0;
      if (wr_period)
        period_sh <= per_din;
      if (wr_duty)
        duty_sh <= per_din;
      stat_pd <= wrap | (stat_pd & ~(wr_stat & per_din[STAT_PD]));
      stat_bd <= burst_end | (stat_bd & ~(wr_stat & per_din[STAT_BD]));
    end
  end

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      cnt      <= '0;
      per_act  <= '0;
      duty_act <= '0;
      pwm_out  <= 1'b0;
    end else begin
      if (!active)
        cnt <= '0;
      else if (tick)
        cnt <= (cnt == per_act) ? '0 : cnt + CNT_ONE;
      if (start || wrap) begin
        per_act  <= period_sh;
        duty_act <= duty_sh;
      end
      pwm_out <= active & ((cnt < duty_act) ^ ctrl_pol);
    end
  end

  assign irq = ctrl_ie & (stat_pd | stat_bd);

  always_comb begin
    per_dout = '0;
    if (reg_rd) begin
      case (reg_ofs)
        OFS_CTRL:   per_dout = {(state == ST_RUN), 10'b0, ctrl_ie, ctrl_presc, ctrl_pol, ctrl_en};
        OFS_PERIOD: per_dout = period_sh;
        OFS_DUTY:   per_dout = duty_sh;
        OFS_CNT:    per_dout = cnt;
        OFS_BURST:  per_dout = burst_rd;
        OFS_STAT:   per_dout = {14'b0, stat_bd, stat_pd};
        default:    per_dout = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ro_pwm_gen.sv
// Directed bench for ro_pwm_gen: waveform table plus hand sequences for stop, reset, shadow and burst.
module tb_ro_pwm_gen;

  logic        mclk = 1'b0;
  logic        puc_rst;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic [15:0] per_dout;
  logic        pwm_out;
  logic        irq;

  int checks = 0;
  int errors = 0;

  localparam logic [13:0] WBASE = 14'h00D0;
  localparam logic [3:0] A_CTRL = 4'h0, A_PER = 4'h2, A_DUTY = 4'h4,
                         A_CNT = 4'h6, A_BURST = 4'h8, A_STAT = 4'hA;

  ro_pwm_gen #(.BASE_ADDR(15'h01A0), .DEC_WD(4), .CNT_W(16)) dut (
    .mclk     (mclk),
    .puc_rst  (puc_rst),
    .per_addr (per_addr),
    .per_din  (per_din),
    .per_en   (per_en),
    .per_we   (per_we),
    .per_dout (per_dout),
    .pwm_out  (pwm_out),
    .irq      (irq)
  );

  always #5 mclk = ~mclk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  typedef struct {
    logic [15:0] period;
    logic [15:0] duty;
    logic [1:0]  presc;
    logic        pol;
    logic        lead;
    int          lead_len;
    int          trail_len;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [3:0] ofs, input logic [15:0] d);
    @(negedge mclk);
    per_en   = 1'b1;
    per_we   = 2'b11;
    per_addr = WBASE | {11'b0, ofs[3:1]};
    per_din  = d;
    @(negedge mclk);
    per_en = 1'b0;
    per_we = 2'b00;
  endtask

  task automatic rd(input logic [3:0] ofs, output logic [15:0] d);
    @(negedge mclk);
    per_en   = 1'b1;
    per_we   = 2'b00;
    per_addr = WBASE | {11'b0, ofs[3:1]};
    #1 d = per_dout;
    per_en = 1'b0;
  endtask

  logic [15:0] rv;
  logic [15:0] ctrl_v;
  logic        expv;
  logic        prev;
  int          plen, pos, w, hi, pulses;

  initial begin
    vt[0] = '{16'd9, 16'd3,  2'd0, 1'b0, 1'b1, 3,  7};
    vt[1] = '{16'd9, 16'd0,  2'd0, 1'b0, 1'b0, 10, 0};
    vt[2] = '{16'd9, 16'd20, 2'd0, 1'b0, 1'b1, 10, 0};
    vt[3] = '{16'd1, 16'd1,  2'd2, 1'b0, 1'b1, 4,  4};
    vt[4] = '{16'd3, 16'd2,  2'd1, 1'b0, 1'b1, 4,  4};
    vt[5] = '{16'd4, 16'd1,  2'd0, 1'b1, 1'b0, 1,  4};

    per_addr = '0; per_din = '0; per_en = 1'b0; per_we = 2'b00;
    puc_rst = 1'b1;
    repeat (3) @(negedge mclk);
    chk("rst pwm_out", {15'b0, pwm_out}, 16'h0000);
    chk("rst irq", {15'b0, irq}, 16'h0000);
    chk("rst per_dout", per_dout, 16'h0000);
    puc_rst = 1'b0;

    rd(A_CTRL, rv); chk("rst CTRL", rv, 16'h0000);
    rd(A_CNT, rv);  chk("rst CNT", rv, 16'h0000);
    rd(A_STAT, rv); chk("rst STAT", rv, 16'h0000);
    wr(A_PER, 16'h1234);
    rd(A_PER, rv);  chk("PERIOD readback", rv, 16'h1234);
    wr(A_CNT, 16'h0005);
    rd(A_CNT, rv);  chk("CNT write ignored", rv, 16'h0000);
    @(negedge mclk);
    per_en = 1'b1; per_we = 2'b00; per_addr = 14'h0001;
    #1 chk("unselected dout", per_dout, 16'h0000);
    per_en = 1'b0;

    // table of steady-state waveforms
    for (int i = 0; i < 6; i++) begin
      wr(A_CTRL, 16'h0000);
      wr(A_STAT, 16'h0003);
      wr(A_PER, vt[i].period);
      wr(A_DUTY, vt[i].duty);
      ctrl_v = {11'b0, 1'b0, vt[i].presc, vt[i].pol, 1'b1};
      wr(A_CTRL, ctrl_v);
      @(negedge mclk);
      chk($sformatf("vec%0d first-edge low", i), {15'b0, pwm_out}, 16'h0000);
      plen = vt[i].lead_len + vt[i].trail_len;
      for (int k = 0; k < 2 * plen; k++) begin
        @(negedge mclk);
        pos  = k % plen;
        expv = (pos < vt[i].lead_len) ? vt[i].lead : ~vt[i].lead;
        chk($sformatf("vec%0d cyc%0d pwm", i, k), {15'b0, pwm_out}, {15'b0, expv});
      end
      rd(A_STAT, rv); chk($sformatf("vec%0d STAT.PD", i), rv & 16'h0001, 16'h0001);
      rd(A_CTRL, rv); chk($sformatf("vec%0d CTRL busy", i), rv, ctrl_v | 16'h8000);
      chk($sformatf("vec%0d irq off", i), {15'b0, irq}, 16'h0000);
    end

    // duty written mid-period applies from next wrap
    wr(A_CTRL, 16'h0000);
    wr(A_PER, 16'd9);
    wr(A_DUTY, 16'd2);
    wr(A_CTRL, 16'h0001);
    @(negedge mclk);
    for (int k = 0; k < 3; k++) begin
      @(negedge mclk);
      chk($sformatf("shadow cyc%0d", k), {15'b0, pwm_out}, (k < 2) ? 16'h0001 : 16'h0000);
    end
    wr(A_DUTY, 16'd5);
    w = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge mclk);
      if (pwm_out) begin
        w = n;
        break;
      end
    end
    chk("shadow rise position", 16'(w), 16'd6);
    hi = 1;
    for (int n = 0; n < 15; n++) begin
      @(negedge mclk);
      if (pwm_out) hi++;
      else break;
    end
    chk("shadow new high len", 16'(hi), 16'd5);

    // EN cleared while high
    wr(A_CTRL, 16'h0000);
    wr(A_DUTY, 16'd8);
    wr(A_CTRL, 16'h0001);
    repeat (2) @(negedge mclk);
    chk("stop pre high", {15'b0, pwm_out}, 16'h0001);
    wr(A_CTRL, 16'h0000);
    @(negedge mclk);
    chk("stop pwm low", {15'b0, pwm_out}, 16'h0000);
    rd(A_CNT, rv);  chk("stop CNT", rv, 16'h0000);
    rd(A_CTRL, rv); chk("stop CTRL", rv, 16'h0000);

    // async reset mid-run
    wr(A_CTRL, 16'h0001);
    repeat (2) @(negedge mclk);
    chk("rst-run pre high", {15'b0, pwm_out}, 16'h0001);
    #1 puc_rst = 1'b1;
    #1 chk("rst-run pwm", {15'b0, pwm_out}, 16'h0000);
    @(negedge mclk);
    puc_rst = 1'b0;
    rd(A_CTRL, rv); chk("rst-run CTRL", rv, 16'h0000);
    rd(A_PER, rv);  chk("rst-run PERIOD", rv, 16'h0000);
    rd(A_CNT, rv);  chk("rst-run CNT", rv, 16'h0000);

    // burst of 3 periods
    wr(A_PER, 16'd3);
    wr(A_DUTY, 16'd1);
    wr(A_BURST, 16'd3);
    wr(A_CTRL, 16'h0011);
    pulses = 0;
    prev = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge mclk);
      if (pwm_out && !prev) pulses++;
      prev = pwm_out;
    end
`ifdef RO_PWM_BURST_EN
    chk("burst pulses", 16'(pulses), 16'd3);
    rd(A_CTRL, rv);  chk("burst CTRL", rv, 16'h0010);
    rd(A_STAT, rv);  chk("burst STAT", rv, 16'h0003);
    chk("burst irq", {15'b0, irq}, 16'h0001);
    wr(A_STAT, 16'h0001);
    rd(A_STAT, rv);  chk("burst STAT after PD clr", rv, 16'h0002);
    chk("burst irq from BD", {15'b0, irq}, 16'h0001);
    rd(A_BURST, rv); chk("burst prog read", rv, 16'd3);
`else
    chk("cont pulses", 16'(pulses), 16'd10);
    rd(A_CTRL, rv);  chk("cont CTRL", rv, 16'h8011);
    rd(A_STAT, rv);  chk("cont STAT.BD", rv & 16'h0002, 16'h0000);
    chk("cont irq from PD", {15'b0, irq}, 16'h0001);
    rd(A_BURST, rv); chk("cont BURST reads 0", rv, 16'h0000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
